// File: rtl/hazard_unit.sv
// hazard_unit: pipeline control for the 16-bit, 8-register processor.
// Decides, each cycle, which pipeline registers load and which are
// flushed/bubbled, based on load-use hazards, taken branches resolved in
// EX/MEM, and the data-memory handshake. Multi-cycle memory accesses freeze
// the pipeline; a wait that lasts TIMEOUT cycles raises a sticky memError.
// Two saturating 16-bit counters record stall cycles and branch flushes.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   idRs, idRt, idUsesRt    source fields of the instruction in IF/ID
//   memRead2, rtOut         ID/EX load flag and load destination
//   branchTaken             EX/MEM branch resolved taken
//   memReq, memReady        data-memory request / completion
//   pcWrite .. exmemWrite   load enables of PC and pipeline registers
//   ifidFlush .. memwbBubble flush/bubble controls of pipeline registers
//   memError                sticky memory-timeout flag
//   stallCycles, flushCount saturating performance counters
module hazard_unit #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  idRs,
    input  logic [2:0]  idRt,
    input  logic        idUsesRt,
    input  logic        memRead2,
    input  logic [2:0]  rtOut,
    input  logic        branchTaken,
    input  logic        memReq,
    input  logic        memReady,
    output logic        pcWrite,
    output logic        ifidWrite,
    output logic        idexWrite,
    output logic        exmemWrite,
    output logic        ifidFlush,
    output logic        idexBubble,
    output logic        exmemFlush,
    output logic        memwbBubble,
    output logic        memError,
    output logic [15:0] stallCycles,
    output logic [15:0] flushCount
);

    typedef enum logic [0:0] {RUN, MEM_WAIT} state_t;

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    state_t      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic        err_q, err_d;
    logic [15:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;
    logic        flush_evt;
    logic        load_use;
    logic        mem_stall;

    // Register 0 is an ordinary register here, so no zero check on rtOut.
    assign load_use  = memRead2 & ((rtOut == idRs) | (idUsesRt & (rtOut == idRt)));
    assign mem_stall = memReq & ~memReady;

    always_comb begin
        pcWrite     = 1'b1;
        ifidWrite   = 1'b1;
        idexWrite   = 1'b1;
        exmemWrite  = 1'b1;
        ifidFlush   = 1'b0;
        idexBubble  = 1'b0;
        exmemFlush  = 1'b0;
        memwbBubble = 1'b0;
        state_d     = state_q;
        wait_d      = wait_q;
        err_d       = err_q;
        flush_evt   = 1'b0;

        // A wait that starts in RUN and a wait that continues in MEM_WAIT
        // freeze identically; a wait that ends falls through to RUN rules.
        if ((state_q == RUN && mem_stall) || (state_q == MEM_WAIT && !memReady)) begin
            pcWrite     = 1'b0;
            ifidWrite   = 1'b0;
            idexWrite   = 1'b0;
            exmemWrite  = 1'b0;
            memwbBubble = 1'b1;
            state_d     = MEM_WAIT;
            if (state_q == RUN) begin
                wait_d = 16'd1;
            end else if (wait_q < TIMEOUT_C) begin
                // Counter stops at TIMEOUT so it can never wrap back.
                wait_d = wait_q + 16'd1;
                if (wait_q + 16'd1 == TIMEOUT_C) begin
                    err_d = 1'b1;
                end
            end
        end else begin
            state_d = RUN;
            wait_d  = 16'd0;
            // Branch wins over load-use: the stalled instruction is flushed anyway.
            if (branchTaken) begin
                ifidFlush  = 1'b1;
                idexBubble = 1'b1;
                exmemFlush = 1'b1;
                flush_evt  = 1'b1;
            end else if (load_use) begin
                pcWrite    = 1'b0;
                ifidWrite  = 1'b0;
                idexBubble = 1'b1;
            end
        end

        stall_d = (!pcWrite && stall_q != CNT_MAX) ? stall_q + 16'd1 : stall_q;
        flush_d = (flush_evt && flush_q != CNT_MAX) ? flush_q + 16'd1 : flush_q;

        if (reset) begin
            pcWrite     = 1'b0;
            ifidWrite   = 1'b0;
            idexWrite   = 1'b0;
            exmemWrite  = 1'b0;
            ifidFlush   = 1'b1;
            idexBubble  = 1'b1;
            exmemFlush  = 1'b1;
            memwbBubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            wait_q  <= 16'd0;
            err_q   <= 1'b0;
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign memError    = err_q;
    assign stallCycles = stall_q;
    assign flushCount  = flush_q;

endmodule
